// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle, MSB chunk first.
// Optional match counter enabled by defining SEQ_CMP_MATCH_COUNT_EN.
module seq_magnitude_compare #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [15:0]      match_count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [CHUNK-1:0] a_top, b_top;

    // Operands are shifted left each step so the chunk under test is always the top one.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        a_top   = a_q[WIDTH-1 -: CHUNK];
        b_top   = b_q[WIDTH-1 -: CHUNK];
        if (SIGNED_CMP != 0 && idx_q == LAST_IDX) begin
            a_top[CHUNK-1] = ~a_top[CHUNK-1];
            b_top[CHUNK-1] = ~b_top[CHUNK-1];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = LAST_IDX;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_top != b_top) begin
                    gt_d    = (a_top > b_top);
                    lt_d    = (a_top < b_top);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = (state_q == COMPARE);
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

`ifdef SEQ_CMP_MATCH_COUNT_EN
    logic [15:0] match_count_q, match_count_d;

    // Saturating count of equal results.
    always_comb begin
        match_count_d = match_count_q;
        if (done_d && eq_d && match_count_q != 16'hFFFF) begin
            match_count_d = match_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_count_q <= 16'd0;
        end else begin
            match_count_q <= match_count_d;
        end
    end

    assign match_count = match_count_q;
`else
    assign match_count = 16'd0;
`endif

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Bench for seq_magnitude_compare (WIDTH=8, CHUNK=2): vector table, corner sequences, random vs model.
module tb_seq_magnitude_compare;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_u = 1'b0, start_s = 1'b0;
    logic [7:0] a_u = '0, b_u = '0, a_s = '0, b_s = '0;
    logic       busy_u, done_u, eq_u, gt_u, lt_u;
    logic       busy_s, done_s, eq_s, gt_s, lt_s;
    logic [15:0] mc_u, mc_s;

    int total = 0;
    int bad   = 0;
    int exp_mc_u = 0;
    int exp_mc_s = 0;

`ifdef SEQ_CMP_MATCH_COUNT_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    seq_magnitude_compare #(.WIDTH(8), .CHUNK(2), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .a(a_u), .b(b_u),
        .busy(busy_u), .done(done_u), .eq(eq_u), .gt(gt_u), .lt(lt_u),
        .match_count(mc_u)
    );

    seq_magnitude_compare #(.WIDTH(8), .CHUNK(2), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .eq(eq_s), .gt(gt_s), .lt(lt_s),
        .match_count(mc_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         sgn;
        logic [7:0] a;
        logic [7:0] b;
        bit         eq;
        bit         gt;
        bit         lt;
        int         lat;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] get_res(input bit sgn);
        return sgn ? {eq_s, gt_s, lt_s} : {eq_u, gt_u, lt_u};
    endfunction

    // Reference: first differing 2-bit chunk (MSB first) decides latency; result from plain arithmetic.
    task automatic model(input bit sgn, input logic [7:0] va, input logic [7:0] vb,
                         output bit m_eq, output bit m_gt, output bit m_lt, output int m_lat);
        int x;
        x     = int'(va ^ vb);
        m_lat = 4;
        for (int k = 0; k < 4; k++) begin
            if (((x >> (6 - 2 * k)) & 3) != 0) begin
                m_lat = k + 1;
                break;
            end
        end
        m_eq = (va == vb);
        if (sgn) m_gt = ($signed(va) > $signed(vb));
        else     m_gt = (va > vb);
        m_lt = !m_eq && !m_gt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_mc_u = 0;
        exp_mc_s = 0;
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, "_busy"}, int'({busy_u, busy_s}), 0);
        check({nm, "_done"}, int'({done_u, done_s}), 0);
        check({nm, "_res_u"}, int'(get_res(1'b0)), 0);
        check({nm, "_res_s"}, int'(get_res(1'b1)), 0);
        check({nm, "_mc"}, int'({mc_u, mc_s}), 0);
    endtask

    // Start a compare, optionally poke start with junk while busy, and check latency and result.
    task automatic run_cmp(input string nm, input bit sgn, input logic [7:0] va, input logic [7:0] vb,
                           input bit x_eq, input bit x_gt, input bit x_lt, input int x_lat,
                           input bit inject, input logic [7:0] ja, input logic [7:0] jb);
        int  n;
        bit  seen;
        @(negedge clk);
        if (sgn) begin a_s = va; b_s = vb; start_s = 1'b1; end
        else     begin a_u = va; b_u = vb; start_u = 1'b1; end
        @(posedge clk);
        #1;
        start_u = 1'b0;
        start_s = 1'b0;
        check({nm, "_busy"}, int'(sgn ? busy_s : busy_u), 1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            if (inject && n == 0 && x_lat > 1) begin
                if (sgn) begin a_s = ja; b_s = jb; start_s = 1'b1; end
                else     begin a_u = ja; b_u = jb; start_u = 1'b1; end
            end
            @(posedge clk);
            #1;
            start_u = 1'b0;
            start_s = 1'b0;
            n++;
            seen = sgn ? done_s : done_u;
        end
        if (!seen) begin
            check({nm, "_timeout"}, 0, 1);
        end else begin
            check({nm, "_lat"}, n, x_lat);
            check({nm, "_res"}, int'(get_res(sgn)), int'({x_eq, x_gt, x_lt}));
            check({nm, "_busy_in_done"}, int'(sgn ? busy_s : busy_u), 0);
            if (x_eq && MC_EN) begin
                if (sgn) exp_mc_s++;
                else     exp_mc_u++;
            end
            check({nm, "_mc"}, int'(sgn ? mc_s : mc_u), sgn ? exp_mc_s : exp_mc_u);
        end
    endtask

    task automatic applyStimulus_random(input int count);
        logic [7:0] ra, rb;
        bit m_eq, m_gt, m_lt, sgn;
        int m_lat;
        for (int i = 0; i < count; i++) begin
            sgn = bit'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
            model(sgn, ra, rb, m_eq, m_gt, m_lt, m_lat);
            run_cmp("rand", sgn, ra, rb, m_eq, m_gt, m_lt, m_lat,
                    bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        bit seen;
        logic [2:0] held;

        vecs[0] = '{0, 8'h00, 8'h00, 1, 0, 0, 4};
        vecs[1] = '{0, 8'h80, 8'h00, 0, 1, 0, 1};
        vecs[2] = '{0, 8'h01, 8'h02, 0, 0, 1, 4};
        vecs[3] = '{0, 8'hFF, 8'hFE, 0, 1, 0, 4};
        vecs[4] = '{0, 8'hC0, 8'h40, 0, 1, 0, 1};
        vecs[5] = '{0, 8'h7F, 8'h80, 0, 0, 1, 1};
        vecs[6] = '{1, 8'hFF, 8'h01, 0, 0, 1, 1};
        vecs[7] = '{1, 8'h7F, 8'h80, 0, 1, 0, 1};
        vecs[8] = '{1, 8'h85, 8'h83, 0, 1, 0, 3};
        vecs[9] = '{1, 8'h00, 8'h00, 1, 0, 0, 4};

        do_reset();
        #1;
        check_idle_zero("reset");

        for (int i = 0; i < 10; i++) begin
            run_cmp($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].lat, 1'b0, 8'h00, 8'h00);
        end

        // Start while busy is ignored; result must then hold with no further done.
        run_cmp("ignore_busy", 0, 8'h34, 8'h38, 0, 0, 1, 3, 1'b1, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        held = get_res(1'b0);
        check("hold_res", int'(held), 3'b001);
        check("hold_done", int'(done_u), 0);

        // Reset mid-compare aborts with no done.
        @(negedge clk);
        a_u = 8'hAA; b_u = 8'hAA; start_u = 1'b1;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_mc_u = 0;
        exp_mc_s = 0;
        check_idle_zero("abort");
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done_u) seen = 1'b1;
        end
        check("abort_no_done", int'(seen), 0);

        // Back-to-back: new start in the done cycle is accepted.
        run_cmp("b2b_first", 0, 8'h80, 8'h00, 0, 1, 0, 1, 1'b0, 8'h00, 8'h00);
        a_u = 8'h00; b_u = 8'h01; start_u = 1'b1;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        check("b2b_accept", int'(busy_u), 1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = done_u;
        end
        check("b2b_lat", n, 4);
        check("b2b_res", int'(get_res(1'b0)), 3'b001);

        applyStimulus_random(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
